mem_access: RTL and testbench
=============================

# mem_access

Memory-access pipeline stage placed directly downstream of the execute stage and upstream of the MEM/WB pipeline register. It takes the execute stage's registered result and, for loads and stores, sequences little-endian byte transfers over the shared byte-wide RAM port; it stalls the upstream pipeline until the transfer completes. Non-memory instructions pass through with one cycle of latency.

## Interface
Parameters:
- ADDR_W, 32, RAM byte-address width.

Ports:
- clk_in  in  1  clock; all state updates on the rising edge
- rst_in  in  1  synchronous, active-high reset
- valid_in  in  1  execute result present this cycle
- rd_in  in  1  register write enable from execute
- rd_val_in  in  `RegBus  ALU result from execute
- rd_addr_in  in  `RegAddrBus  destination register
- inst_type_in  in  `InstTypeBus  instruction type
- mem_addr_in  in  ADDR_W  effective address for load/store
- mem_val_in  in  `RegBus  store data (rs2 value)
- ram_grant_in  in  1  arbiter grants the byte port this cycle
- ram_din  in  8  read data; returns the byte addressed in the previous cycle
- valid_out  out  1  result valid to MEM/WB
- rd_out  out  1  write enable to MEM/WB
- rd_val_out  out  `RegBus  write-back value
- rd_addr_out  out  `RegAddrBus  destination register
- stall_req_out  out  1  combinational; upstream holds its outputs while high
- ram_a_out  out  ADDR_W  byte address
- ram_wr_out  out  1  1 = write ram_dout, 0 = read
- ram_dout  out  8  write data

## Operation
- Byte count N by type: LB/LBU/SB = 1, LH/LHU/SH = 2, LW/SW = 4.
- Byte k uses address mem_addr_in + k, with modulo 2^ADDR_W wrap. Order is little-endian: byte k maps to bits [8k+7:8k].
- FSM states:
  - IDLE: a valid memory op moves to ACCESS. The transition coincides with issuing byte 0 if the grant is held; otherwise the FSM waits in IDLE with stall high.
  - ACCESS: issue a byte in each granted cycle. When all N bytes are issued and, for loads, all N are captured, move to DONE.
  - DONE: lasts exactly one cycle, then returns to IDLE.
- Issue and capture use separate counters (issue_cnt, cap_cnt, 0..4).
  - A read issued in cycle t is captured in cycle t+1 regardless of the grant in t+1.
  - Grant low: no issue, ram_wr_out = 0, ram_a_out holds.
- Stores:
  - ram_wr_out = 1 and ram_dout = mem_val_in[8k+7:8k] in the issue cycle.
  - rd_out is forced to 0.
- Loads:
  - Assembled bytes are sign-extended (LB, LH) or zero-extended (LBU, LHU), then written to rd_val_out.
  - rd_out = rd_in.
- stall_req_out = valid_in AND is_mem_op AND state != DONE.
- Non-memory op or valid_in = 0 (state IDLE): output registers load the inputs directly.
  - valid_out = valid_in.
  - rd_out = rd_in AND valid_in.
- At the DONE-cycle edge the output registers load a bubble (valid_out = 0, rd_out = 0). This prevents the still-present memory instruction from being re-accepted.
- Reset:
  - All outputs are 0, the FSM is IDLE and both counters are 0.
  - Reset mid-store aborts the transfer. Bytes already written stay written; there is no rollback.
  - Reset mid-load discards partial data.

## Timing
- Non-memory: result on outputs 1 cycle after presentation; no stall.
- Load, full grant (op presented in cycle 0):
  - Issue in cycles 0..N-1; capture in cycles 1..N.
  - Result registered at the end of cycle N; DONE is cycle N+1, with valid_out = 1 in that cycle.
  - stall_req_out is high in cycles 0..N.
- Store, full grant: writes in cycles 0..N-1; DONE and valid_out = 1 (rd_out = 0) in cycle N; stall is high in cycles 0..N-1.
- Each cycle of grant loss during issue adds one cycle.
- valid_out is a single-cycle pulse per instruction.

## Structure
- Load/store type codes (LB..SW) and the byte-count function belong in the shared defines package alongside the existing `InstTypeBus codes. State encodings live in the same package.
- One sub-module: mem_load_ext. It is combinational and does sign/zero extension from 8/16/32 assembled bits based on inst_type.
- Estimated size: 200–300 lines total.

## Test plan
- ADDI passthrough, rd_val_in = 0x0000_0005, valid_in = 1 → next cycle valid_out = 1, rd_val_out = 5, stall never asserted.
- LW at 0x100, RAM 0x100..0x103 = 78 56 34 12, grant held → ram_a_out = 0x100..0x103 in cycles 0..3, stall high for 5 cycles, rd_val_out = 0x1234_5678 with valid_out = 1 in cycle 5.
- LB reading 0x80 → rd_val_out = 0xFFFF_FF80; LBU reading 0x80 → rd_val_out = 0x0000_0080. LH reading bytes 0xFE 0xFF → 0xFFFF_FFFE.
- SH mem_val_in = 0xAABB_CCDD at 0x200, grant dropped in cycle 1 → writes DD@0x200 in cycle 0 and CC@0x201 in cycle 2; DONE in cycle 3, valid_out = 1, rd_out = 0.
- SW at 0xFFFF_FFFE → bytes written to 0xFFFF_FFFE, 0xFFFF_FFFF, 0x0, 0x1 (address wrap).
- rst_in asserted in cycle 2 of an LW → next cycle all outputs 0, state IDLE; a subsequent ADDI passes through normally.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared defines for the memory-access stage: bus widths, instruction type
// codes, FSM state encodings and the load/store decode helpers.
package mem_access_pkg;

  localparam int REG_W       = 32;
  localparam int REG_ADDR_W  = 5;
  localparam int INST_TYPE_W = 4;

  localparam logic [INST_TYPE_W-1:0] INST_NOP = 4'd0;
  localparam logic [INST_TYPE_W-1:0] INST_ALU = 4'd1;
  localparam logic [INST_TYPE_W-1:0] INST_LB  = 4'd2;
  localparam logic [INST_TYPE_W-1:0] INST_LH  = 4'd3;
  localparam logic [INST_TYPE_W-1:0] INST_LW  = 4'd4;
  localparam logic [INST_TYPE_W-1:0] INST_LBU = 4'd5;
  localparam logic [INST_TYPE_W-1:0] INST_LHU = 4'd6;
  localparam logic [INST_TYPE_W-1:0] INST_SB  = 4'd7;
  localparam logic [INST_TYPE_W-1:0] INST_SH  = 4'd8;
  localparam logic [INST_TYPE_W-1:0] INST_SW  = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } mem_state_e;

  function automatic logic is_load(input logic [INST_TYPE_W-1:0] t);
    return (t == INST_LB) || (t == INST_LH) || (t == INST_LW) ||
           (t == INST_LBU) || (t == INST_LHU);
  endfunction

  function automatic logic is_store(input logic [INST_TYPE_W-1:0] t);
    return (t == INST_SB) || (t == INST_SH) || (t == INST_SW);
  endfunction

  function automatic logic [2:0] byte_count(input logic [INST_TYPE_W-1:0] t);
    case (t)
      INST_LB, INST_LBU, INST_SB: return 3'd1;
      INST_LH, INST_LHU, INST_SH: return 3'd2;
      INST_LW, INST_SW:           return 3'd4;
      default:                    return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_if.sv
// Execute-side inputs, MEM/WB-side outputs and the byte-wide RAM port of the
// memory-access stage.
interface mem_access_if
  import mem_access_pkg::*;
#(
  parameter int ADDR_W = 32
) ();

  logic                   valid_in;
  logic                   rd_in;
  logic [REG_W-1:0]       rd_val_in;
  logic [REG_ADDR_W-1:0]  rd_addr_in;
  logic [INST_TYPE_W-1:0] inst_type_in;
  logic [ADDR_W-1:0]      mem_addr_in;
  logic [REG_W-1:0]       mem_val_in;
  logic                   ram_grant_in;
  logic [7:0]             ram_din;

  logic                   valid_out;
  logic                   rd_out;
  logic [REG_W-1:0]       rd_val_out;
  logic [REG_ADDR_W-1:0]  rd_addr_out;
  logic                   stall_req_out;
  logic [ADDR_W-1:0]      ram_a_out;
  logic                   ram_wr_out;
  logic [7:0]             ram_dout;

  modport slave (
    input  valid_in, rd_in, rd_val_in, rd_addr_in, inst_type_in,
           mem_addr_in, mem_val_in, ram_grant_in, ram_din,
    output valid_out, rd_out, rd_val_out, rd_addr_out, stall_req_out,
           ram_a_out, ram_wr_out, ram_dout
  );

  modport master (
    output valid_in, rd_in, rd_val_in, rd_addr_in, inst_type_in,
           mem_addr_in, mem_val_in, ram_grant_in, ram_din,
    input  valid_out, rd_out, rd_val_out, rd_addr_out, stall_req_out,
           ram_a_out, ram_wr_out, ram_dout
  );

endinterface

// File: rtl/mem_load_ext.sv
// Sign/zero extension of an assembled little-endian load value to register
// width, selected by the load type.
module mem_load_ext
  import mem_access_pkg::*;
(
  input  logic [INST_TYPE_W-1:0] inst_type,
  input  logic [REG_W-1:0]       raw,
  output logic [REG_W-1:0]       ext
);

  always_comb begin
    ext = raw;
    case (inst_type)
      INST_LB:  ext = {{24{raw[7]}}, raw[7:0]};
      INST_LBU: ext = {24'h0, raw[7:0]};
      INST_LH:  ext = {{16{raw[15]}}, raw[15:0]};
      INST_LHU: ext = {16'h0, raw[15:0]};
      default:  ext = raw;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// Memory-access pipeline stage: sequences byte transfers for loads/stores over
// a shared byte RAM port and stalls upstream until the access completes.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | passthrough; a memory op waits here for the first grant
// ST_ACCESS | issuing bytes on granted cycles, capturing load returns
// ST_DONE   | one-cycle result slot; output registers then take a bubble
module mem_access
  import mem_access_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic          clk_in,
  input  logic          rst_in,
  mem_access_if.slave   bus
);

  mem_state_e        state_q, state_d;
  logic [2:0]        issue_cnt_q, issue_cnt_d;
  logic [2:0]        cap_cnt_q, cap_cnt_d;
  logic              rd_pend_q;
  logic [REG_W-1:0]  load_buf_q;
  logic [ADDR_W-1:0] ram_a_q;

  logic              load_op, store_op, mem_op;
  logic [2:0]        n_bytes;
  logic              issue, finish;
  logic [ADDR_W-1:0] addr_now;
  logic [REG_W-1:0]  assembled, load_ext;

  logic                  valid_q, rd_q;
  logic [REG_W-1:0]      rd_val_q;
  logic [REG_ADDR_W-1:0] rd_addr_q;

  always_comb begin
    load_op  = bus.valid_in && is_load(bus.inst_type_in);
    store_op = bus.valid_in && is_store(bus.inst_type_in);
    mem_op   = load_op || store_op;
    n_bytes  = byte_count(bus.inst_type_in);
    addr_now = bus.mem_addr_in + ADDR_W'(issue_cnt_q);

    issue = bus.ram_grant_in && mem_op &&
            ((state_q == ST_IDLE) ||
             ((state_q == ST_ACCESS) && (issue_cnt_q < n_bytes)));

    issue_cnt_d = issue_cnt_q + {2'b00, issue};
    cap_cnt_d   = cap_cnt_q + {2'b00, rd_pend_q};

    // Done once the last byte is out and, for loads, the last return is in.
    finish = mem_op && (state_q != ST_DONE) && (issue_cnt_d == n_bytes) &&
             (store_op || (cap_cnt_d == n_bytes));

    assembled = load_buf_q;
    if (rd_pend_q) assembled[8*cap_cnt_q[1:0] +: 8] = bus.ram_din;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (finish)     state_d = ST_DONE;
        else if (issue) state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (!mem_op)     state_d = ST_IDLE;
        else if (finish) state_d = ST_DONE;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= ST_IDLE;
      issue_cnt_q <= 3'd0;
      cap_cnt_q   <= 3'd0;
      rd_pend_q   <= 1'b0;
      load_buf_q  <= '0;
      ram_a_q     <= '0;
    end else begin
      state_q <= state_d;
      if (finish || (state_d == ST_IDLE)) begin
        issue_cnt_q <= 3'd0;
        cap_cnt_q   <= 3'd0;
      end else begin
        issue_cnt_q <= issue_cnt_d;
        cap_cnt_q   <= cap_cnt_d;
      end
      rd_pend_q  <= issue && load_op;
      load_buf_q <= assembled;
      if (issue) ram_a_q <= addr_now;
    end
  end

  mem_load_ext u_load_ext (
    .inst_type (bus.inst_type_in),
    .raw       (assembled),
    .ext       (load_ext)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      valid_q   <= 1'b0;
      rd_q      <= 1'b0;
      rd_val_q  <= '0;
      rd_addr_q <= '0;
    end else if (state_q == ST_DONE) begin
      // Bubble so the instruction still on the inputs is not accepted twice.
      valid_q <= 1'b0;
      rd_q    <= 1'b0;
    end else if (finish) begin
      valid_q   <= 1'b1;
      rd_q      <= load_op && bus.rd_in;
      rd_val_q  <= load_op ? load_ext : bus.rd_val_in;
      rd_addr_q <= bus.rd_addr_in;
    end else if (mem_op) begin
      valid_q <= 1'b0;
      rd_q    <= 1'b0;
    end else begin
      valid_q   <= bus.valid_in;
      rd_q      <= bus.rd_in && bus.valid_in;
      rd_val_q  <= bus.rd_val_in;
      rd_addr_q <= bus.rd_addr_in;
    end
  end

  assign bus.valid_out     = valid_q;
  assign bus.rd_out        = rd_q;
  assign bus.rd_val_out    = rd_val_q;
  assign bus.rd_addr_out   = rd_addr_q;
  assign bus.stall_req_out = mem_op && (state_q != ST_DONE);
  assign bus.ram_wr_out    = issue && store_op;
  assign bus.ram_a_out     = issue ? addr_now : ram_a_q;
  assign bus.ram_dout      = (issue && store_op) ?
                             bus.mem_val_in[8*issue_cnt_q[1:0] +: 8] : 8'h00;

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: passthrough, loads with extension, stores
// with grant loss and address wrap, and reset in the middle of a load.
module tb_mem_access;
  import mem_access_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  mem_access_if #(.ADDR_W(32)) bus ();

  mem_access #(.ADDR_W(32)) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  function automatic logic [7:0] rom_byte(input logic [31:0] a);
    case (a)
      32'h100: return 8'h78;
      32'h101: return 8'h56;
      32'h102: return 8'h34;
      32'h103: return 8'h12;
      32'h300: return 8'h80;
      32'h310: return 8'hFE;
      32'h311: return 8'hFF;
      default: return 8'h00;
    endcase
  endfunction

  // RAM returns the byte addressed in the previous cycle.
  always @(posedge clk) bus.ram_din <= rom_byte(bus.ram_a_out);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] t, input logic [31:0] a,
                       input logic [31:0] mv, input logic g);
    bus.valid_in     = v;
    bus.inst_type_in = t;
    bus.mem_addr_in  = a;
    bus.mem_val_in   = mv;
    bus.ram_grant_in = g;
  endtask

  task automatic do_load(input string tag, input logic [3:0] t, input logic [31:0] a,
                         input int n, input logic [31:0] exp);
    next_cyc();
    drive(1'b1, t, a, 32'h0, 1'b1);
    bus.rd_in = 1'b1; bus.rd_addr_in = 5'd9; bus.rd_val_in = 32'h0;
    #2;
    for (int k = 0; k <= n; k++) begin
      if (k > 0) begin
        next_cyc();
        #2;
      end
      chk({tag, "_stall"}, bus.stall_req_out, 32'd1);
      chk({tag, "_valid_low"}, bus.valid_out, 32'd0);
      if (k < n) begin
        chk({tag, "_addr"}, bus.ram_a_out, a + 32'(k));
        chk({tag, "_wr"}, bus.ram_wr_out, 32'd0);
      end
    end
    next_cyc();
    #2;
    chk({tag, "_valid"}, bus.valid_out, 32'd1);
    chk({tag, "_val"}, bus.rd_val_out, exp);
    chk({tag, "_rd"}, bus.rd_out, 32'd1);
    chk({tag, "_rdaddr"}, bus.rd_addr_out, 32'd9);
    chk({tag, "_stall_done"}, bus.stall_req_out, 32'd0);
    next_cyc();
    drive(1'b0, INST_NOP, 32'h0, 32'h0, 1'b1);
    #2;
    chk({tag, "_bubble"}, bus.valid_out, 32'd0);
  endtask

  initial begin
    drive(1'b0, INST_NOP, 32'h0, 32'h0, 1'b1);
    bus.rd_in = 1'b0; bus.rd_val_in = 32'h0; bus.rd_addr_in = 5'd0;

    // Reset state
    next_cyc();
    next_cyc();
    #2;
    chk("rst_valid", bus.valid_out, 32'd0);
    chk("rst_rd", bus.rd_out, 32'd0);
    chk("rst_val", bus.rd_val_out, 32'd0);
    chk("rst_a", bus.ram_a_out, 32'd0);
    chk("rst_wr", bus.ram_wr_out, 32'd0);
    rst = 1'b0;

    // ADDI passthrough
    next_cyc();
    drive(1'b1, INST_ALU, 32'h0, 32'h0, 1'b1);
    bus.rd_in = 1'b1; bus.rd_val_in = 32'h5; bus.rd_addr_in = 5'd3;
    #2;
    chk("addi_stall0", bus.stall_req_out, 32'd0);
    next_cyc();
    drive(1'b0, INST_NOP, 32'h0, 32'h0, 1'b1);
    bus.rd_val_in = 32'h0;
    #2;
    chk("addi_valid", bus.valid_out, 32'd1);
    chk("addi_val", bus.rd_val_out, 32'h5);
    chk("addi_rd", bus.rd_out, 32'd1);
    chk("addi_rdaddr", bus.rd_addr_out, 32'd3);
    chk("addi_stall1", bus.stall_req_out, 32'd0);
    next_cyc();
    #2;
    chk("addi_pulse", bus.valid_out, 32'd0);

    // Loads with full grant
    do_load("lw",  INST_LW,  32'h100, 4, 32'h1234_5678);
    do_load("lb",  INST_LB,  32'h300, 1, 32'hFFFF_FF80);
    do_load("lbu", INST_LBU, 32'h300, 1, 32'h0000_0080);
    do_load("lh",  INST_LH,  32'h310, 2, 32'hFFFF_FFFE);

    // SH with grant dropped in cycle 1
    next_cyc();
    drive(1'b1, INST_SH, 32'h200, 32'hAABB_CCDD, 1'b1);
    bus.rd_in = 1'b1;
    #2;
    chk("sh_c0_wr", bus.ram_wr_out, 32'd1);
    chk("sh_c0_a", bus.ram_a_out, 32'h200);
    chk("sh_c0_d", bus.ram_dout, 32'hDD);
    chk("sh_c0_stall", bus.stall_req_out, 32'd1);
    next_cyc();
    bus.ram_grant_in = 1'b0;
    #2;
    chk("sh_c1_wr", bus.ram_wr_out, 32'd0);
    chk("sh_c1_a", bus.ram_a_out, 32'h200);
    chk("sh_c1_stall", bus.stall_req_out, 32'd1);
    next_cyc();
    bus.ram_grant_in = 1'b1;
    #2;
    chk("sh_c2_wr", bus.ram_wr_out, 32'd1);
    chk("sh_c2_a", bus.ram_a_out, 32'h201);
    chk("sh_c2_d", bus.ram_dout, 32'hCC);
    chk("sh_c2_valid", bus.valid_out, 32'd0);
    next_cyc();
    #2;
    chk("sh_c3_valid", bus.valid_out, 32'd1);
    chk("sh_c3_rd", bus.rd_out, 32'd0);
    chk("sh_c3_stall", bus.stall_req_out, 32'd0);
    chk("sh_c3_wr", bus.ram_wr_out, 32'd0);
    next_cyc();
    drive(1'b0, INST_NOP, 32'h0, 32'h0, 1'b1);
    #2;
    chk("sh_bubble", bus.valid_out, 32'd0);

    // SW across the top of the address space
    next_cyc();
    drive(1'b1, INST_SW, 32'hFFFF_FFFE, 32'h1122_3344, 1'b1);
    #2;
    chk("sw_a0", bus.ram_a_out, 32'hFFFF_FFFE);
    chk("sw_d0", bus.ram_dout, 32'h44);
    chk("sw_w0", bus.ram_wr_out, 32'd1);
    next_cyc();
    #2;
    chk("sw_a1", bus.ram_a_out, 32'hFFFF_FFFF);
    chk("sw_d1", bus.ram_dout, 32'h33);
    next_cyc();
    #2;
    chk("sw_a2", bus.ram_a_out, 32'h0000_0000);
    chk("sw_d2", bus.ram_dout, 32'h22);
    next_cyc();
    #2;
    chk("sw_a3", bus.ram_a_out, 32'h0000_0001);
    chk("sw_d3", bus.ram_dout, 32'h11);
    chk("sw_stall3", bus.stall_req_out, 32'd1);
    next_cyc();
    #2;
    chk("sw_valid", bus.valid_out, 32'd1);
    chk("sw_rd", bus.rd_out, 32'd0);
    chk("sw_stall_done", bus.stall_req_out, 32'd0);
    next_cyc();
    drive(1'b0, INST_NOP, 32'h0, 32'h0, 1'b1);
    #2;
    chk("sw_bubble", bus.valid_out, 32'd0);

    // Reset in cycle 2 of an LW, then ADDI
    next_cyc();
    drive(1'b1, INST_LW, 32'h100, 32'h0, 1'b1);
    bus.rd_in = 1'b1; bus.rd_addr_in = 5'd4;
    next_cyc();
    next_cyc();
    rst = 1'b1;
    next_cyc();
    rst = 1'b0;
    drive(1'b0, INST_NOP, 32'h0, 32'h0, 1'b1);
    bus.rd_in = 1'b0;
    #2;
    chk("rlw_valid", bus.valid_out, 32'd0);
    chk("rlw_rd", bus.rd_out, 32'd0);
    chk("rlw_val", bus.rd_val_out, 32'd0);
    chk("rlw_rdaddr", bus.rd_addr_out, 32'd0);
    chk("rlw_a", bus.ram_a_out, 32'd0);
    chk("rlw_stall", bus.stall_req_out, 32'd0);
    next_cyc();
    drive(1'b1, INST_ALU, 32'h0, 32'h0, 1'b1);
    bus.rd_in = 1'b1; bus.rd_val_in = 32'h9; bus.rd_addr_in = 5'd6;
    #2;
    chk("radd_stall", bus.stall_req_out, 32'd0);
    next_cyc();
    drive(1'b0, INST_NOP, 32'h0, 32'h0, 1'b1);
    #2;
    chk("radd_valid", bus.valid_out, 32'd1);
    chk("radd_val", bus.rd_val_out, 32'h9);
    chk("radd_rdaddr", bus.rd_addr_out, 32'd6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
